probe_hook_arbiter: RTL
=======================

# probe_hook_arbiter

Shares one probe upload channel among NPROBES hardware probes. Each probe is captured into a one-word holding buffer tagged with a timestamp, and a round-robin arbiter serialises pending buffers as header+data word pairs onto the DATAUP/DATAVALID/ACK handshake. The host enables, disables and flushes probes through the CMDEN/CMD command port, and restarts the timestamp base with CTIMER. The block sits between the instrumented design and the probe hook crumb, and presents the same upload and command signal set.

## Interface
Parameters:
- NPROBES, 4, number of probe inputs (1..16)

Ports:
- UCLK  in  1  sole clock; all state on rising edge
- URST_N  in  1  reset, asynchronous, active-low
- PROBE_VALID  in  NPROBES  per-probe capture request
- PROBE_DATA  in  32*NPROBES  per-probe word; probe i at [32i+31:32i]
- PROBE_READY  out  NPROBES  buffer i empty (= ~full[i])
- DATAUP  out  32  upload word
- DATAVALID  out  1  DATAUP valid
- ACK  in  1  consumer accepts DATAUP this edge
- DELAY  out  1  OR of full[i] over enabled probes
- CMDEN  in  1  command strobe, one cycle
- CMD  in  19  [18:16] opcode, [15:0] probe number
- CTIMER  in  1  timestamp clear

## Operation
- State per probe: en[i], full[i], ovf[i], buf_data[i] (32 bits), buf_ts[i] (16 bits).
- Timestamp: a 32-bit counter that increments every cycle and wraps. When CTIMER is 1 on an edge, the counter loads 0 instead.
- Capture: at an edge with PROBE_VALID[i] & en[i] & ~full[i], set full[i] and load buf_data[i] with PROBE_DATA[i] and buf_ts[i] with ts[15:0].
- Drop: at an edge with PROBE_VALID[i] & en[i] & full[i], set ovf[i]; the buffer is unchanged. Valid on a disabled probe is ignored.
- Commands, applied at the CMDEN edge:
  - 0: disable probe n.
  - 1: enable probe n.
  - 2: enable all.
  - 3: disable all.
  - 4: flush probe n (clear full and ovf).
  - 5–7: no-op.
  - A per-probe opcode with n >= NPROBES is ignored.
- Disable or flush effect on buffers:
  - It clears full[i] for every affected probe that is not the current grant.
  - The in-flight grant always completes.
  - Disabling also clears ovf[i] for non-granted affected probes.
- Arbiter FSM: IDLE, HDR, DAT.
  - IDLE: if any full[i] & en[i], grant the first such i at or after rr_ptr (wrapping), latch g=i, go to HDR.
  - HDR: DATAVALID=1, DATAUP={ovf[g], g zero-extended to 15 bits, buf_ts[g]}. On ACK go to DAT and clear ovf[g].
  - DAT: DATAVALID=1, DATAUP=buf_data[g]. On ACK clear full[g], set rr_ptr=(g+1) mod NPROBES, go to IDLE.
  - IDLE: DATAVALID=0, DATAUP=0.
- Simultaneous events:
  - A capture on probe g in the same edge as its DAT ACK is not accepted, because PROBE_READY[g] was 0.
  - A drop on probe g in the same edge as its HDR ACK: the set wins, so ovf[g] stays 1.
  - CMDEN in the same edge as a capture on the same probe: the command wins (disable or flush leaves the buffer empty; enable does not capture in that edge).
- Reset (URST_N=0, asynchronous):
  - en, full, ovf, rr_ptr, ts, buffers all 0; FSM=IDLE.
  - Outputs: DATAVALID=0, DATAUP=0, DELAY=0, PROBE_READY=all 1.
  - Reset mid-transfer abandons the pair; no completion is owed.

## Timing
- All outputs decode registered state only; there is no combinational path from ACK, CMD or PROBE_VALID to any output.
- Capture at edge k: PROBE_READY[i] falls and DELAY rises after k. Grant at edge k+1, so DATAVALID rises after k+1.
- DATAUP and DATAVALID are held stable until ACK is sampled. ACK while DATAVALID=0 is ignored.
- A pair with immediate ACKs takes 3 cycles (HDR, DAT, IDLE bubble). Maximum upload rate is 2 words per 3 cycles.
- PROBE_READY[g] rises the cycle after the DAT ACK edge.
- The header timestamp is the low 16 bits at the capture edge. A CTIMER at the same edge as a capture records the pre-clear value.

## Test plan
- Single word:
  - Stimulus: reset; CMD=1, n=2; ts cleared by CTIMER; probe 2 valid with 0xDEADBEEF 10 cycles later; ACK held 1.
  - Required: header 0x0002_000A then data 0xDEADBEEF, DATAVALID high exactly 2 cycles, PROBE_READY[2]=1 afterwards.
- Round-robin:
  - Stimulus: enable all; all 4 probes capture in the same cycle.
  - Required: upload order 0,1,2,3. A second burst with rr_ptr=1 (probe 0 served alone first) yields 1,2,3,0.
- Backpressure and overflow:
  - Stimulus: ACK=0 for 20 cycles; probe 0 pulses valid a second time.
  - Required: DATAUP and DATAVALID stable throughout, DELAY=1, next header bit31=1, following header bit31=0.
- Disable during transfer:
  - Stimulus: probes 0 and 1 full; grant 0 in HDR; CMD=3.
  - Required: probe 0 pair completes, probe 1 buffer discarded, FSM returns to IDLE with DATAVALID=0.
- Invalid probe number:
  - Stimulus: CMD=1, n=7 with NPROBES=4.
  - Required: no enable changes; later valids on probes 0–3 are ignored.
- Async reset mid-DAT:
  - Stimulus: assert URST_N=0 between edges.
  - Required: DATAVALID=0 and PROBE_READY=all 1 immediately; all enables 0 after release.

Source files
------------

// File: rtl/probe_hook_arbiter.sv
// ============================================================================
// probe_hook_arbiter: per-probe timestamped holding buffers, round-robin
// serialised as header+data word pairs onto the DATAUP/DATAVALID/ACK channel.
// Revision: 1.0
// ============================================================================
`default_nettype none

module probe_hook_arbiter #(
    parameter int NPROBES = 4
) (
    input  logic                   UCLK,
    input  logic                   URST_N,
    input  logic [NPROBES-1:0]     PROBE_VALID,
    input  logic [32*NPROBES-1:0]  PROBE_DATA,
    output logic [NPROBES-1:0]     PROBE_READY,
    output logic [31:0]            DATAUP,
    output logic                   DATAVALID,
    input  logic                   ACK,
    output logic                   DELAY,
    input  logic                   CMDEN,
    input  logic [18:0]            CMD,
    input  logic                   CTIMER
);

    localparam int PW = (NPROBES > 1) ? $clog2(NPROBES) : 1;

    localparam logic [2:0] OP_DIS    = 3'd0;
    localparam logic [2:0] OP_ENA    = 3'd1;
    localparam logic [2:0] OP_ENAALL = 3'd2;
    localparam logic [2:0] OP_DISALL = 3'd3;
    localparam logic [2:0] OP_FLUSH  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DAT  = 2'd2
    } state_t;

    state_t               state_q;
    logic [PW-1:0]        g_q;
    logic [PW-1:0]        rr_q;
    logic                 dv_q;

    logic [NPROBES-1:0]   en_q,   en_d;
    logic [NPROBES-1:0]   full_q, full_d;
    logic [NPROBES-1:0]   ovf_q,  ovf_d;
    logic [31:0]          buf_data_q [NPROBES];
    logic [15:0]          buf_ts_q   [NPROBES];

    // Only the low half of the 32-bit free-running timestamp is ever
    // observable, so only that half is kept.
    logic [15:0]          ts_q;

    logic [2:0]           w_op;
    logic                 w_busy;
    logic [NPROBES-1:0]   w_dis;
    logic [NPROBES-1:0]   w_ena;
    logic [NPROBES-1:0]   w_aff;
    logic [NPROBES-1:0]   w_kill;
    logic [NPROBES-1:0]   w_cap;
    logic [NPROBES-1:0]   w_drop;
    logic [NPROBES-1:0]   w_hdr_ack;
    logic [NPROBES-1:0]   w_dat_ack;
    logic [NPROBES-1:0]   w_req;
    logic                 w_found;
    logic [PW-1:0]        w_pick;
    logic [31:0]          w_up;

    assign w_op   = CMD[18:16];
    assign w_busy = (state_q != ST_IDLE);

    // Per-probe command decode and event qualification. A command touching
    // a probe takes precedence over any capture or drop on that probe.
    for (genvar i = 0; i < NPROBES; i++) begin : g_probe
        logic w_hit;
        logic w_granted;

        assign w_hit      = (CMD[15:0] == 16'(i));
        assign w_granted  = w_busy && (g_q == PW'(i));

        assign w_dis[i]   = CMDEN && (((w_op == OP_DIS) && w_hit) || (w_op == OP_DISALL));
        assign w_ena[i]   = CMDEN && (((w_op == OP_ENA) && w_hit) || (w_op == OP_ENAALL));
        assign w_aff[i]   = w_dis[i] || w_ena[i] || (CMDEN && (w_op == OP_FLUSH) && w_hit);
        assign w_kill[i]  = (w_dis[i] || (CMDEN && (w_op == OP_FLUSH) && w_hit)) && !w_granted;

        assign w_cap[i]   = PROBE_VALID[i] && en_q[i] && !full_q[i] && !w_aff[i];
        assign w_drop[i]  = PROBE_VALID[i] && en_q[i] &&  full_q[i] && !w_aff[i];

        assign w_hdr_ack[i] = (state_q == ST_HDR) && ACK && (g_q == PW'(i));
        assign w_dat_ack[i] = (state_q == ST_DAT) && ACK && (g_q == PW'(i));

        assign w_req[i]   = full_q[i] && en_q[i] && !w_kill[i];
    end

    always_comb begin
        en_d   = en_q;
        full_d = full_q;
        ovf_d  = ovf_q;
        for (int i = 0; i < NPROBES; i++) begin
            if (w_dis[i]) en_d[i] = 1'b0;
            if (w_ena[i]) en_d[i] = 1'b1;
            if (w_dat_ack[i] || w_kill[i]) full_d[i] = 1'b0;
            if (w_cap[i])                  full_d[i] = 1'b1;
            // A drop on the same edge as the header ACK must not be lost.
            if (w_hdr_ack[i] || w_kill[i]) ovf_d[i] = 1'b0;
            if (w_drop[i])                 ovf_d[i] = 1'b1;
        end
    end

    // Round-robin search starting at rr_q, wrapping at NPROBES.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_pick  = '0;
        idx     = 0;
        for (int k = 0; k < NPROBES; k++) begin
            idx = (int'(rr_q) + k) % NPROBES;
            if (!w_found && w_req[idx]) begin
                w_found = 1'b1;
                w_pick  = PW'(idx);
            end
        end
    end

    always_ff @(posedge UCLK or negedge URST_N) begin
        if (!URST_N) begin
            en_q   <= '0;
            full_q <= '0;
            ovf_q  <= '0;
            ts_q   <= '0;
            for (int i = 0; i < NPROBES; i++) begin
                buf_data_q[i] <= '0;
                buf_ts_q[i]   <= '0;
            end
        end else begin
            en_q   <= en_d;
            full_q <= full_d;
            ovf_q  <= ovf_d;
            ts_q   <= CTIMER ? 16'd0 : ts_q + 16'd1;
            for (int i = 0; i < NPROBES; i++) begin
                if (w_cap[i]) begin
                    buf_data_q[i] <= PROBE_DATA[32*i +: 32];
                    buf_ts_q[i]   <= ts_q;
                end
            end
        end
    end

    always_ff @(posedge UCLK or negedge URST_N) begin
        if (!URST_N) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            rr_q    <= '0;
            dv_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_found) begin
                        g_q     <= w_pick;
                        state_q <= ST_HDR;
                        dv_q    <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (ACK) state_q <= ST_DAT;
                end
                ST_DAT: begin
                    if (ACK) begin
                        state_q <= ST_IDLE;
                        dv_q    <= 1'b0;
                        rr_q    <= (g_q == PW'(NPROBES - 1)) ? '0 : g_q + PW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    dv_q    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_up = '0;
        case (state_q)
            ST_HDR:  w_up = {ovf_q[g_q], 15'(g_q), buf_ts_q[g_q]};
            ST_DAT:  w_up = buf_data_q[g_q];
            default: w_up = '0;
        endcase
    end

    assign DATAUP      = w_up;
    assign DATAVALID   = dv_q;
    assign PROBE_READY = ~full_q;
    assign DELAY       = |(full_q & en_q);

endmodule

`default_nettype wire
